// File: rtl/led_pattern_counter.sv
// led_pattern_counter
//   LED pattern generator for the board LED bank. A free-running prescaler
//   produces step pulses at a slow or fast rate. The push button selects the
//   rate. On each step the pattern engine advances a binary or Gray counter,
//   moves a bouncing scanner, or holds. The result is registered onto the LED
//   pins with selectable drive polarity.
//
// Ports
//   clk   in   system clock, all logic on the rising edge
//   rst   in   synchronous reset, active-high
//   sw_n  in   raw push button, 1 = released, 0 = pressed (asynchronous)
//   mode  in   2'b00 binary, 2'b01 Gray, 2'b10 scanner, 2'b11 hold (asynchronous)
//   dir   in   1 = up / scanner starts upward, 0 = down (asynchronous)
//   led   out  LED drive, inverted when ACTIVE_LOW
//   step  out  one-cycle pulse whenever the prescaler reaches its step point
module led_pattern_counter #(
  parameter int LED_W      = 8,
  parameter int CNT_W      = 32,
  parameter int SLOW_TAP   = 22,
  parameter int FAST_TAP   = 20,
  parameter int DEB_W      = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_n,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [LED_W-1:0] led,
  output logic             step
);

  typedef enum logic [1:0] {
    MODE_BIN  = 2'b00,
    MODE_GRAY = 2'b01,
    MODE_SCAN = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam int POS_W = $clog2(LED_W);

  localparam logic [CNT_W-1:0] SLOW_MASK = {{(CNT_W-SLOW_TAP){1'b0}}, {SLOW_TAP{1'b1}}};
  localparam logic [CNT_W-1:0] FAST_MASK = {{(CNT_W-FAST_TAP){1'b0}}, {FAST_TAP{1'b1}}};
  localparam logic [CNT_W-1:0] PRESC_ONE = CNT_W'(1);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
  localparam logic [LED_W-1:0] CNT_ONE   = LED_W'(1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(LED_W - 1);

  // Lit pattern to pin level.
  function automatic logic [LED_W-1:0] drive(input logic [LED_W-1:0] lit);
    drive = ACTIVE_LOW ? ~lit : lit;
  endfunction

  // Display value for a given mode. Hold is resolved by the caller.
  function automatic logic [LED_W-1:0] display(input mode_e m,
                                               input logic [LED_W-1:0] c,
                                               input logic [POS_W-1:0] p);
    case (m)
      MODE_GRAY: display = c ^ (c >> 1);
      MODE_SCAN: display = CNT_ONE << p;
      default:   display = c;
    endcase
  endfunction

  localparam logic [LED_W-1:0] LED_OFF = drive('0);

  // ---- stage p0/p1: two-flop synchronisers on the asynchronous inputs
  logic  sw_p0, sw_p1;
  logic  dir_p0, dir_p1;
  mode_e mode_p0, mode_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_p0   <= 1'b1;
      sw_p1   <= 1'b1;
      dir_p0  <= 1'b1;
      dir_p1  <= 1'b1;
      mode_p0 <= MODE_BIN;
      mode_p1 <= MODE_BIN;
    end else begin
      sw_p0   <= sw_n;
      sw_p1   <= sw_p0;
      dir_p0  <= dir;
      dir_p1  <= dir_p0;
      mode_p0 <= mode_e'(mode);
      mode_p1 <= mode_p0;
    end
  end

  // ---- debounce: accept a new button level only after it has differed
  //      from the debounced level for 2^DEB_W consecutive cycles
  logic             deb_q;
  logic [DEB_W-1:0] deb_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q   <= 1'b1;
      deb_cnt <= '0;
    end else if (sw_p1 != deb_q) begin
      if (&deb_cnt) begin
        deb_q   <= sw_p1;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_ONE;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // ---- prescaler and step generation
  // The prescaler is never cleared on a rate change, so a new rate simply
  // takes effect at the next all-ones match of the selected low bits.
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] tap_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_ONE;
    end
  end

  assign tap_mask = deb_q ? SLOW_MASK : FAST_MASK;
  assign step     = ((presc & tap_mask) == tap_mask);

  // ---- pattern engine next-state
  // mode_q holds the synced mode seen last cycle; a difference marks a mode
  // change, which takes priority over a coincident step.
  logic [LED_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             sdir_q, sdir_d;
  mode_e            mode_q, last_mode, disp_mode;
  logic             mode_chg;
  logic             advance;

  always_comb begin
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    sdir_d   = sdir_q;
    mode_chg = (mode_p1 != mode_q);
    advance  = step && !mode_chg;

    if (mode_chg && (mode_p1 == MODE_SCAN)) begin
      pos_d  = '0;
      sdir_d = dir_p1;
    end else if (advance) begin
      case (mode_p1)
        MODE_BIN, MODE_GRAY: begin
          cnt_d = dir_p1 ? (cnt_q + CNT_ONE) : (cnt_q - CNT_ONE);
        end
        MODE_SCAN: begin
          // Reflect at the ends on the same step: no dwell.
          if (sdir_q) begin
            if (pos_q == POS_LAST) begin
              pos_d  = POS_LAST - POS_ONE;
              sdir_d = 1'b0;
            end else begin
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d  = POS_ONE;
              sdir_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Hold shows whatever the last non-hold mode displayed.
    disp_mode = (mode_p1 == MODE_HOLD) ? last_mode : mode_p1;
  end

  // ---- stage p2: engine state and registered LED drive
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pos_q     <= '0;
      sdir_q    <= 1'b1;
      mode_q    <= MODE_BIN;
      last_mode <= MODE_BIN;
      led       <= LED_OFF;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      sdir_q <= sdir_d;
      mode_q <= mode_p1;
      if (mode_p1 != MODE_HOLD) begin
        last_mode <= mode_p1;
      end
      led <= drive(display(disp_mode, cnt_d, pos_d));
    end
  end

endmodule

// File: tb/tb_led_pattern_counter.sv
module tb_led_pattern_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_n;
  logic [1:0] mode;
  logic       dir;
  logic [3:0] led;
  logic       step;

  int vectors = 0;
  int errs    = 0;
  bit chk_en  = 1'b0;

  led_pattern_counter #(
    .LED_W(4), .CNT_W(8), .SLOW_TAP(4), .FAST_TAP(2), .DEB_W(3), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .sw_n(sw_n), .mode(mode), .dir(dir), .led(led), .step(step)
  );

  always #5 clk = ~clk;

  // Reference model: counter value, scanner phase in a 6-step bounce cycle,
  // prescaler as an integer, debounce as a stability count.
  int         m_presc, m_dcnt, m_cnt, m_phase;
  bit         m_deb;
  bit         sw0, sw1, d0, d1;
  bit   [1:0] ms0, ms1, m_prev, m_last;
  logic [3:0] m_led;

  function automatic int scan_pos(input int ph);
    return (ph < 4) ? ph : 6 - ph;
  endfunction

  function automatic logic [3:0] exp_disp(input bit [1:0] m, input int c, input int ph);
    case (m)
      2'd1:    return 4'(c ^ (c >> 1));
      2'd2:    return 4'(1 << scan_pos(ph));
      default: return 4'(c);
    endcase
  endfunction

  function automatic bit exp_step(input int presc, input bit deb);
    int per;
    per = deb ? 16 : 4;
    return (presc % per) == (per - 1);
  endfunction

  always @(posedge clk) begin : model
    bit       st;
    bit [1:0] cur, dm;
    if (rst) begin
      m_presc = 0; m_dcnt = 0; m_cnt = 0; m_phase = 0; m_deb = 1'b1;
      sw0 = 1'b1; sw1 = 1'b1; d0 = 1'b1; d1 = 1'b1;
      ms0 = 2'd0; ms1 = 2'd0; m_prev = 2'd0; m_last = 2'd0;
      m_led = 4'hF;
    end else begin
      st  = exp_step(m_presc, m_deb);
      cur = ms1;
      if (cur != m_prev) begin
        if (cur == 2'd2) m_phase = 0;
      end else if (st) begin
        if (cur <= 2'd1) m_cnt = (m_cnt + (d1 ? 1 : 15)) % 16;
        else if (cur == 2'd2) m_phase = (m_phase + 1) % 6;
      end
      dm    = (cur == 2'd3) ? m_last : cur;
      m_led = ~exp_disp(dm, m_cnt, m_phase);
      if (cur != 2'd3) m_last = cur;
      m_prev = cur;
      if (sw1 != m_deb) begin
        if (m_dcnt == 7) begin
          m_deb  = sw1;
          m_dcnt = 0;
        end else begin
          m_dcnt++;
        end
      end else begin
        m_dcnt = 0;
      end
      sw1 = sw0; sw0 = sw_n;
      ms1 = ms0; ms0 = mode;
      d1  = d0;  d0  = dir;
      m_presc = (m_presc + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (led !== m_led) begin
        errs++;
        $display("FAIL led_model t=%0t got %b want %b", $time, led, m_led);
      end
      vectors++;
      if (step !== exp_step(m_presc, m_deb)) begin
        errs++;
        $display("FAIL step_model t=%0t got %b want %b", $time, step, exp_step(m_presc, m_deb));
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance at least one cycle, then until step is seen; n = cycles advanced.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step !== 1'b1 && n < 40);
    vectors++;
    if (step !== 1'b1) begin
      errs++;
      $display("FAIL step_timeout got no step want step within 40 cycles");
    end
  endtask

  task automatic step_led(input logic [3:0] exp, input string nm);
    int n;
    wait_step(n);
    @(negedge clk);
    chk(nm, led, exp);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int         n;
    logic [3:0] e;
    logic [3:0] scan_exp [8];
    scan_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011};

    rst = 1'b1; sw_n = 1'b1; mode = 2'b00; dir = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_led", led, 4'b1111);
    chk("reset_step", step, 1'b0);

    // Binary up, slow rate, full wrap.
    rst = 1'b0;
    wait_step(n);
    chk("first_step_latency", n, 15);
    @(negedge clk);
    chk("bin_up_1", led, 4'b1110);
    wait_step(n);
    chk("slow_period", n, 15);
    @(negedge clk);
    chk("bin_up_2", led, 4'b1101);
    for (int i = 3; i <= 16; i++) begin
      e = ~4'(i);
      step_led(e, "bin_up_seq");
    end
    chk("bin_wrap", led, 4'b1111);

    // Binary down from reset.
    dir = 1'b0;
    do_reset(2);
    wait_step(n);
    chk("down_latency", n, 15);
    @(negedge clk);
    chk("bin_down_first", led, 4'b0000);

    // Short glitch is rejected; long press gives fast rate; release restores.
    sw_n = 1'b0;
    repeat (5) @(negedge clk);
    sw_n = 1'b1;
    wait_step(n);
    wait_step(n);
    chk("glitch_period", n, 16);
    sw_n = 1'b0;
    repeat (12) @(negedge clk);
    wait_step(n);
    wait_step(n);
    chk("fast_period", n, 4);
    sw_n = 1'b1;
    repeat (12) @(negedge clk);
    wait_step(n);
    wait_step(n);
    chk("release_period", n, 16);

    // Gray switch landing on a step cycle: mode change wins, count stays 5.
    dir = 1'b1;
    do_reset(2);
    repeat (5) wait_step(n);
    repeat (14) @(negedge clk);
    mode = 2'b01;
    repeat (3) @(negedge clk);
    chk("gray_of_5", led, 4'b1000);
    step_led(4'b1010, "gray_of_6");

    // Scanner bounce.
    mode = 2'b10;
    repeat (3) @(negedge clk);
    chk("scan_entry", led, 4'b1110);
    for (int i = 0; i < 8; i++) step_led(scan_exp[i], "scan_seq");

    // Hold mid-scan at position 2.
    mode = 2'b11;
    for (int i = 0; i < 10; i++) step_led(4'b1011, "hold_frozen");

    // One-cycle reset mid-operation.
    do_reset(1);
    chk("midrst_led", led, 4'b1111);
    chk("midrst_step", step, 1'b0);
    wait_step(n);
    chk("midrst_presc_restart", n, 15);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
